// File: rtl/pmod_pattern_checker_pkg.sv
// pmod_pattern_checker_pkg
//   Shared definitions for the PMOD walking-one checker.
//   - chk_state_t : checker FSM encodings (ST_HUNT / ST_LOCKED)
//   - onehot8()   : true when exactly one bit of a byte is set
//   - rotl8()     : rotate a byte left by one (0x80 wraps to 0x01)
`timescale 1ns/1ps
package pmod_pattern_checker_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_t;

    function automatic logic onehot8(input logic [7:0] v);
        // Clearing the lowest set bit leaves zero only for a power of two.
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/pmod_pattern_checker_rx_settle_filter.sv
// pmod_pattern_checker_rx_settle_filter
//   Brings the asynchronous looped-back byte into the clock domain and
//   commits it once it has been stable long enough.
//   Ports:
//     clk_16mhz  in   system clock
//     rst_n      in   asynchronous active-low reset
//     pmod_rx    in   8-bit looped-back pattern (asynchronous)
//     commit     out  1-cycle strobe: rx_value is a new stable value
//     rx_value   out  synchronised byte (the value being committed on commit)
//     committed  out  most recently committed byte (0x00 after reset)
`timescale 1ns/1ps
module pmod_pattern_checker_rx_settle_filter #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk_16mhz,
    input  logic       rst_n,
    input  logic [7:0] pmod_rx,
    output logic       commit,
    output logic [7:0] rx_value,
    output logic [7:0] committed
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic [7:0]    sync1_reg;
    logic [7:0]    sync2_reg;
    logic [7:0]    rx_d_reg;
    logic [SW-1:0] settle_reg;
    logic [SW-1:0] settle_next;
    logic [7:0]    committed_reg;
    logic          changed;

    // Independent 2-FF synchroniser per bit; the settle counter absorbs
    // any bit-to-bit skew between the lanes.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sync
            always_ff @(posedge clk_16mhz or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= pmod_rx[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    assign changed = (sync2_reg != rx_d_reg);

    always_comb begin
        settle_next = settle_reg;
        if (changed) begin
            settle_next = '0;
        end else if (settle_reg != SETTLE_LAST) begin
            settle_next = settle_reg + 1'b1;
        end
    end

    // The counter only clears the cycle after a change, so "changed" also
    // gates the strobe: a glitch arriving while the counter sits at its end
    // value must not be committed.
    assign commit    = (settle_reg == SETTLE_LAST) && !changed && (sync2_reg != committed_reg);
    assign rx_value  = sync2_reg;
    assign committed = committed_reg;

    always_ff @(posedge clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            rx_d_reg      <= 8'h00;
            settle_reg    <= '0;
            committed_reg <= 8'h00;
        end else begin
            rx_d_reg   <= sync2_reg;
            settle_reg <= settle_next;
            if (commit) begin
                committed_reg <= sync2_reg;
            end
        end
    end

endmodule

// File: rtl/pmod_pattern_checker.sv
// pmod_pattern_checker
//   Receive-end checker for a walking-one byte looped back over a PMOD.
//   Locks onto the rotating sequence, counts good/bad steps and drives
//   pass/fail LEDs.
//   Ports:
//     clk_16mhz    in   system clock
//     rst_n        in   asynchronous active-low reset
//     pmod_rx      in   looped-back pattern (asynchronous)
//     clr          in   synchronous clear of counters and bad_pattern
//     locked       out  checker is locked onto the sequence
//     step_ok      out  pulse: good step while locked
//     step_err     out  pulse: bad step while locked
//     lock_lost    out  pulse: lock dropped on watchdog timeout
//     good_count   out  saturating good-step count
//     err_count    out  saturating bad-step count
//     bad_pattern  out  value of the most recent bad step
//     led_pass     out  locked and no errors
//     led_fail     out  at least one error
`timescale 1ns/1ps
module pmod_pattern_checker
    import pmod_pattern_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int LOCK_STEPS     = 4,
    parameter int TIMEOUT_CYCLES = 48000,
    parameter int CNT_W          = 16
) (
    input  logic             clk_16mhz,
    input  logic             rst_n,
    input  logic [7:0]       pmod_rx,
    input  logic             clr,
    output logic             locked,
    output logic             step_ok,
    output logic             step_err,
    output logic             lock_lost,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       bad_pattern,
    output logic             led_pass,
    output logic             led_fail
);

    localparam int HW = $clog2(LOCK_STEPS + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HIT_LAST = HW'(LOCK_STEPS - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

    logic       commit;
    logic [7:0] rx_value;
    logic [7:0] committed;
    logic       step_good;

    chk_state_t       state_reg, state_next;
    logic [HW-1:0]    hit_reg, hit_next;
    logic [WW-1:0]    wd_reg, wd_next;
    logic             ok_reg, ok_next;
    logic             err_reg, err_next;
    logic             lost_reg, lost_next;
    logic [CNT_W-1:0] good_reg, good_next;
    logic [CNT_W-1:0] errc_reg, errc_next;
    logic [7:0]       bad_reg, bad_next;

    pmod_pattern_checker_rx_settle_filter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_filter (
        .clk_16mhz(clk_16mhz),
        .rst_n    (rst_n),
        .pmod_rx  (pmod_rx),
        .commit   (commit),
        .rx_value (rx_value),
        .committed(committed)
    );

    // A non-one-hot predecessor (reset value, or a previous bad step)
    // carries no sequence information, so any one-hot value reseeds it.
    assign step_good = onehot8(rx_value) &&
                       (onehot8(committed) ? (rx_value == rotl8(committed)) : 1'b1);

    always_comb begin
        state_next = state_reg;
        hit_next   = hit_reg;
        wd_next    = wd_reg;
        ok_next    = 1'b0;
        err_next   = 1'b0;
        lost_next  = 1'b0;
        good_next  = good_reg;
        errc_next  = errc_reg;
        bad_next   = bad_reg;

        case (state_reg)
            ST_HUNT: begin
                wd_next = '0;
                if (commit) begin
                    if (!step_good) begin
                        hit_next = '0;
                    end else if (hit_reg == HIT_LAST) begin
                        state_next = ST_LOCKED;
                        hit_next   = '0;
                    end else begin
                        hit_next = hit_reg + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (commit) begin
                    wd_next = '0;
                    if (step_good) begin
                        ok_next = 1'b1;
                        if (good_reg != '1) good_next = good_reg + 1'b1;
                    end else begin
                        err_next = 1'b1;
                        bad_next = rx_value;
                        if (errc_reg != '1) errc_next = errc_reg + 1'b1;
                    end
                end else if (wd_reg == WD_LAST) begin
                    state_next = ST_HUNT;
                    lost_next  = 1'b1;
                    hit_next   = '0;
                    wd_next    = '0;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_HUNT;
                hit_next   = '0;
                wd_next    = '0;
            end
        endcase

        // Clear overrides any same-cycle update; the FSM keeps running.
        if (clr) begin
            good_next = '0;
            errc_next = '0;
            bad_next  = 8'h00;
        end
    end

    always_ff @(posedge clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_HUNT;
            hit_reg   <= '0;
            wd_reg    <= '0;
            ok_reg    <= 1'b0;
            err_reg   <= 1'b0;
            lost_reg  <= 1'b0;
            good_reg  <= '0;
            errc_reg  <= '0;
            bad_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            hit_reg   <= hit_next;
            wd_reg    <= wd_next;
            ok_reg    <= ok_next;
            err_reg   <= err_next;
            lost_reg  <= lost_next;
            good_reg  <= good_next;
            errc_reg  <= errc_next;
            bad_reg   <= bad_next;
        end
    end

    assign locked      = (state_reg == ST_LOCKED);
    assign step_ok     = ok_reg;
    assign step_err    = err_reg;
    assign lock_lost   = lost_reg;
    assign good_count  = good_reg;
    assign err_count   = errc_reg;
    assign bad_pattern = bad_reg;
    assign led_pass    = locked && (errc_reg == '0);
    assign led_fail    = (errc_reg != '0);

endmodule

// File: tb/tb_pmod_pattern_checker.sv
`timescale 1ns/1ps
module tb_pmod_pattern_checker;

    localparam int CNT_W = 16;

    logic             clk_16mhz = 1'b0;
    logic             rst_n     = 1'b0;
    logic [7:0]       pmod_rx   = 8'h00;
    logic             clr       = 1'b0;
    logic             locked;
    logic             step_ok;
    logic             step_err;
    logic             lock_lost;
    logic [CNT_W-1:0] good_count;
    logic [CNT_W-1:0] err_count;
    logic [7:0]       bad_pattern;
    logic             led_pass;
    logic             led_fail;

    int checks   = 0;
    int failures = 0;

    always #31 clk_16mhz = ~clk_16mhz;

    pmod_pattern_checker #(
        .SETTLE_CYCLES (4),
        .LOCK_STEPS    (4),
        .TIMEOUT_CYCLES(64),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_16mhz  (clk_16mhz),
        .rst_n      (rst_n),
        .pmod_rx    (pmod_rx),
        .clr        (clr),
        .locked     (locked),
        .step_ok    (step_ok),
        .step_err   (step_err),
        .lock_lost  (lock_lost),
        .good_count (good_count),
        .err_count  (err_count),
        .bad_pattern(bad_pattern),
        .led_pass   (led_pass),
        .led_fail   (led_fail)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One pattern step, 20 cycles long. Pulses must be absent at +6 and
    // match the expectation at exactly +7 edges (SETTLE_CYCLES+3).
    task automatic do_step(input logic [7:0] v, input logic eok, input logic eerr,
                           input logic with_clr);
        @(negedge clk_16mhz);
        pmod_rx = v;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_16mhz);
            #1;
            if (i == 6) begin
                chk("pre_step_ok", step_ok, 1'b0);
                chk("pre_step_err", step_err, 1'b0);
                if (with_clr) clr = 1'b1;
            end
            if (i == 7) begin
                clr = 1'b0;
                chk("step_ok", step_ok, eok);
                chk("step_err", step_err, eerr);
            end
        end
        $display("step rx=0x%02h locked=%0d good=%0d err=%0d bad=0x%02h",
                 v, locked, good_count, err_count, bad_pattern);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"},   locked, 1'b0);
        chk({tag, "_ok"},       step_ok, 1'b0);
        chk({tag, "_err"},      step_err, 1'b0);
        chk({tag, "_lost"},     lock_lost, 1'b0);
        chk({tag, "_good"},     good_count, 0);
        chk({tag, "_errc"},     err_count, 0);
        chk({tag, "_bad"},      bad_pattern, 8'h00);
        chk({tag, "_led_pass"}, led_pass, 1'b0);
        chk({tag, "_led_fail"}, led_fail, 1'b0);
    endtask

    initial begin
        logic any_pulse;

        #5;
        chk_all_zero("reset");
        repeat (3) @(posedge clk_16mhz);
        @(negedge clk_16mhz);
        rst_n = 1'b1;

        // Lock acquisition: four good commits in HUNT, no pulses there.
        do_step(8'h01, 1'b0, 1'b0, 1'b0);
        do_step(8'h02, 1'b0, 1'b0, 1'b0);
        do_step(8'h04, 1'b0, 1'b0, 1'b0);
        chk("hunt_locked", locked, 1'b0);
        chk("hunt_good", good_count, 0);
        do_step(8'h08, 1'b0, 1'b0, 1'b0);
        chk("lock_rise", locked, 1'b1);
        do_step(8'h10, 1'b1, 1'b0, 1'b0);
        chk("good_1", good_count, 1);
        chk("led_pass_1", led_pass, 1'b1);
        chk("led_fail_1", led_fail, 1'b0);

        // Rotation through the 0x80 -> 0x01 wrap.
        do_step(8'h20, 1'b1, 1'b0, 1'b0);
        do_step(8'h40, 1'b1, 1'b0, 1'b0);
        do_step(8'h80, 1'b1, 1'b0, 1'b0);
        do_step(8'h01, 1'b1, 1'b0, 1'b0);
        chk("good_wrap", good_count, 5);
        chk("err_wrap", err_count, 0);

        // Bad step keeps lock.
        do_step(8'h02, 1'b1, 1'b0, 1'b0);
        do_step(8'h05, 1'b0, 1'b1, 1'b0);
        chk("err_1", err_count, 1);
        chk("bad_pat_1", bad_pattern, 8'h05);
        chk("locked_after_err", locked, 1'b1);
        chk("led_fail_err", led_fail, 1'b1);
        chk("led_pass_err", led_pass, 1'b0);

        // Non-one-hot predecessor: any one-hot value is accepted.
        do_step(8'h08, 1'b1, 1'b0, 1'b0);
        chk("good_reseed", good_count, 7);

        // Short glitch back to the committed value: nothing happens.
        any_pulse = 1'b0;
        @(negedge clk_16mhz);
        pmod_rx = 8'hFF;
        @(negedge clk_16mhz);
        @(negedge clk_16mhz);
        pmod_rx = 8'h08;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_16mhz);
            #1;
            any_pulse = any_pulse | step_ok | step_err;
        end
        chk("glitch_pulse", any_pulse, 1'b0);
        chk("glitch_good", good_count, 7);
        chk("glitch_err", err_count, 1);
        $display("glitch 0x08->0xFF->0x08 good=%0d err=%0d", good_count, err_count);

        // Build err_count to 3, then clear in the same cycle as a bad step.
        do_step(8'h03, 1'b0, 1'b1, 1'b0);
        do_step(8'h06, 1'b0, 1'b1, 1'b0);
        chk("err_3", err_count, 3);
        chk("bad_pat_3", bad_pattern, 8'h06);
        do_step(8'h0C, 1'b0, 1'b1, 1'b1);
        chk("clr_err", err_count, 0);
        chk("clr_bad", bad_pattern, 8'h00);
        chk("clr_good", good_count, 0);
        chk("clr_led_fail", led_fail, 1'b0);
        chk("clr_locked", locked, 1'b1);
        chk("clr_led_pass", led_pass, 1'b1);

        // Watchdog: last commit at step edge 7, lock_lost exactly 64 later.
        do_step(8'h10, 1'b1, 1'b0, 1'b0);
        for (int i = 21; i <= 75; i++) begin
            @(posedge clk_16mhz);
            #1;
            chk($sformatf("lock_lost_t%0d", i), lock_lost, (i == 71) ? 1'b1 : 1'b0);
            if (i == 70) chk("locked_pre_to", locked, 1'b1);
            if (i == 71) chk("locked_post_to", locked, 1'b0);
        end
        chk("to_good_hold", good_count, 1);
        $display("timeout locked=%0d good=%0d", locked, good_count);

        // Reset, reseed from 0x00, relock, then reset mid-run.
        @(negedge clk_16mhz);
        pmod_rx = 8'h00;
        #3 rst_n = 1'b0;
        #1 chk_all_zero("rst1");
        repeat (2) @(posedge clk_16mhz);
        @(negedge clk_16mhz);
        rst_n = 1'b1;
        do_step(8'h04, 1'b0, 1'b0, 1'b0);
        do_step(8'h08, 1'b0, 1'b0, 1'b0);
        do_step(8'h10, 1'b0, 1'b0, 1'b0);
        do_step(8'h20, 1'b0, 1'b0, 1'b0);
        chk("relock", locked, 1'b1);
        do_step(8'h41, 1'b0, 1'b1, 1'b0);
        chk("relock_err", err_count, 1);
        chk("relock_bad", bad_pattern, 8'h41);
        @(negedge clk_16mhz);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("rst2");
        $display("mid-run reset locked=%0d good=%0d err=%0d", locked, good_count, err_count);
        repeat (2) @(posedge clk_16mhz);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
